// File: rtl/duck_flight_ctrl.sv
// Duck flight controller: spawns the duck above the grass, flies and bounces it inside the
// play field, and runs the shot/fall and escape sequences, moving once per movement tick.
module duck_flight_ctrl #(
  parameter int          SCREEN_W     = 1024,
  parameter int          DUCK_W       = 96,
  parameter int          DUCK_H       = 60,
  parameter int          GROUND_Y     = 600,
  parameter int          MOVE_DIV     = 650_000,
  parameter int          STEP_X       = 4,
  parameter int          STEP_Y       = 3,
  parameter int          HIT_HOLD     = 30,
  parameter int          FLIGHT_TICKS = 800,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hunt_start,
  input  logic        duck_hit,
  output logic [11:0] duck_xpos,
  output logic [11:0] duck_ypos,
  output logic [1:0]  duck_dir,
  output logic        duck_alive,
  output logic        duck_fall_done,
  output logic        duck_escaped
);
  localparam int DIV_W  = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int FC_W   = ($clog2(FLIGHT_TICKS + 1) > 6) ? $clog2(FLIGHT_TICKS + 1) : 6;
  localparam int HOLD_W = ($clog2(HIT_HOLD + 1) > 1) ? $clog2(HIT_HOLD + 1) : 1;

  localparam logic [11:0] X_MAX = 12'(SCREEN_W - DUCK_W);
  localparam logic [11:0] Y_MAX = 12'(GROUND_Y - DUCK_H);
  localparam logic [11:0] SX    = 12'(STEP_X);
  localparam logic [11:0] SY    = 12'(STEP_Y);
  localparam logic [11:0] SF    = 12'(2 * STEP_Y);

  typedef enum logic [2:0] {IDLE, SPAWN, FLYING, SHOT, FALLING, ESCAPING} state_t;

  state_t              state_q, state_d;
  logic [11:0]         xpos_q, xpos_d, ypos_q, ypos_d;
  logic [1:0]          dir_q, dir_d;
  logic                alive_q, alive_d, fall_done_q, fall_done_d, escaped_q, escaped_d;
  logic [DIV_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [FC_W-1:0]     flight_cnt_q, flight_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic                tick, y_bounce;
  logic [11:0]         spawn_r;

  always_comb begin
    state_d      = state_q;
    xpos_d       = xpos_q;
    ypos_d       = ypos_q;
    dir_d        = dir_q;
    flight_cnt_d = flight_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    fall_done_d  = 1'b0;
    escaped_d    = 1'b0;
    y_bounce     = 1'b0;
    spawn_r      = {2'b00, lfsr_q[9:0]};
    tick         = (tick_cnt_q == DIV_W'(MOVE_DIV - 1));
    tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
    // Galois step, taps x^16+x^14+x^13+x^11
    lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    if (state_q != IDLE && !hunt_start) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (hunt_start) state_d = SPAWN;
        SPAWN: begin
          xpos_d       = (spawn_r >= X_MAX) ? spawn_r - X_MAX : spawn_r;
          ypos_d       = Y_MAX;
          dir_d        = {1'b1, lfsr_q[10]};
          flight_cnt_d = '0;
          state_d      = FLYING;
        end
        FLYING: begin
          if (duck_hit) begin
            hold_cnt_d = '0;
            state_d    = SHOT;
          end else if (tick) begin
            if (dir_q[0]) begin
              if (xpos_q + SX >= X_MAX) begin xpos_d = X_MAX; dir_d[0] = 1'b0; end
              else xpos_d = xpos_q + SX;
            end else begin
              if (xpos_q < SX) begin xpos_d = '0; dir_d[0] = 1'b1; end
              else xpos_d = xpos_q - SX;
            end
            if (dir_q[1]) begin
              if (ypos_q < SY) begin ypos_d = '0; dir_d[1] = 1'b0; y_bounce = 1'b1; end
              else ypos_d = ypos_q - SY;
            end else begin
              if (ypos_q + SY >= Y_MAX) begin ypos_d = Y_MAX; dir_d[1] = 1'b1; y_bounce = 1'b1; end
              else ypos_d = ypos_q + SY;
            end
            // periodic vertical re-roll yields to a bounce in the same tick
            if (!y_bounce && flight_cnt_q[5:0] == 6'h3f) dir_d[1] = lfsr_q[3];
            flight_cnt_d = flight_cnt_q + 1'b1;
            if (flight_cnt_q == FC_W'(FLIGHT_TICKS - 1)) begin
              dir_d[1] = 1'b1;
              state_d  = ESCAPING;
            end
          end
        end
        SHOT: if (tick) begin
          if (hold_cnt_q == HOLD_W'(HIT_HOLD - 1)) begin
            dir_d[1] = 1'b0;
            state_d  = FALLING;
          end else hold_cnt_d = hold_cnt_q + 1'b1;
        end
        FALLING: if (tick) begin
          if (ypos_q + SF >= Y_MAX) begin
            ypos_d      = Y_MAX;
            fall_done_d = 1'b1;
            state_d     = hunt_start ? SPAWN : IDLE;
          end else ypos_d = ypos_q + SF;
        end
        ESCAPING: if (tick) begin
          if (ypos_q < SY) begin
            ypos_d    = '0;
            escaped_d = 1'b1;
            state_d   = hunt_start ? SPAWN : IDLE;
          end else ypos_d = ypos_q - SY;
        end
        default: state_d = IDLE;
      endcase
    end
    alive_d = (state_d == FLYING) || (state_d == ESCAPING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      xpos_q       <= '0;
      ypos_q       <= Y_MAX;
      dir_q        <= '0;
      alive_q      <= 1'b0;
      fall_done_q  <= 1'b0;
      escaped_q    <= 1'b0;
      tick_cnt_q   <= '0;
      flight_cnt_q <= '0;
      hold_cnt_q   <= '0;
      lfsr_q       <= LFSR_SEED;
    end else begin
      state_q      <= state_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      dir_q        <= dir_d;
      alive_q      <= alive_d;
      fall_done_q  <= fall_done_d;
      escaped_q    <= escaped_d;
      tick_cnt_q   <= tick_cnt_d;
      flight_cnt_q <= flight_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      lfsr_q       <= lfsr_d;
    end
  end

  assign duck_xpos      = xpos_q;
  assign duck_ypos      = ypos_q;
  assign duck_dir       = dir_q;
  assign duck_alive     = alive_q;
  assign duck_fall_done = fall_done_q;
  assign duck_escaped   = escaped_q;
endmodule

// File: tb/tb_duck_flight_ctrl.sv
// Bench for duck_flight_ctrl: scenario tasks plus randomized traffic, all checked against
// a cycle-level behavioural model of the duck written from the flight rules.
module tb_duck_flight_ctrl;
  localparam int MD = 2, FT = 20, HH = 3;
  localparam int S_IDLE = 0, S_SPAWN = 1, S_FLY = 2, S_SHOT = 3, S_FALL = 4, S_ESC = 5;

  logic clk = 1'b0, rst = 1'b1, hunt_start = 1'b0, duck_hit = 1'b0;
  logic [11:0] duck_xpos, duck_ypos;
  logic [1:0]  duck_dir;
  logic        duck_alive, duck_fall_done, duck_escaped;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  duck_flight_ctrl #(.MOVE_DIV(MD), .FLIGHT_TICKS(FT), .HIT_HOLD(HH)) dut (
    .clk(clk), .rst(rst), .hunt_start(hunt_start), .duck_hit(duck_hit),
    .duck_xpos(duck_xpos), .duck_ypos(duck_ypos), .duck_dir(duck_dir),
    .duck_alive(duck_alive), .duck_fall_done(duck_fall_done), .duck_escaped(duck_escaped));

  // behavioural model state
  int m_st = S_IDLE, m_x = 0, m_y = 540, m_fcnt = 0, m_hcnt = 0, m_cyc = 0;
  bit [1:0] m_dir = 0;
  bit m_alive = 0, m_fd = 0, m_esc = 0, m_tick = 0, m_yb = 0;
  bit [15:0] m_lfsr = 16'hACE1;

  function automatic bit [15:0] lfsr_next(input bit [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_st = S_IDLE; m_x = 0; m_y = 540; m_dir = 0; m_alive = 0; m_fd = 0; m_esc = 0;
      m_fcnt = 0; m_hcnt = 0; m_lfsr = 16'hACE1; m_cyc = 0;
    end else begin
      m_tick = (m_cyc % MD) == MD - 1;
      m_fd = 0; m_esc = 0;
      if (!hunt_start) m_st = S_IDLE;
      else case (m_st)
        S_IDLE: m_st = S_SPAWN;
        S_SPAWN: begin
          m_x = m_lfsr % 1024;
          if (m_x >= 928) m_x = m_x - 928;
          m_y = 540; m_dir = {1'b1, m_lfsr[10]}; m_fcnt = 0; m_st = S_FLY;
        end
        S_FLY: if (duck_hit) begin m_st = S_SHOT; m_hcnt = 0; end
          else if (m_tick) begin
            if (m_dir[0]) begin
              if (m_x + 4 >= 928) begin m_x = 928; m_dir[0] = 0; end else m_x = m_x + 4;
            end else begin
              if (m_x < 4) begin m_x = 0; m_dir[0] = 1; end else m_x = m_x - 4;
            end
            m_yb = 0;
            if (m_dir[1]) begin
              if (m_y < 3) begin m_y = 0; m_dir[1] = 0; m_yb = 1; end else m_y = m_y - 3;
            end else begin
              if (m_y + 3 >= 540) begin m_y = 540; m_dir[1] = 1; m_yb = 1; end else m_y = m_y + 3;
            end
            if (!m_yb && m_fcnt % 64 == 63) m_dir[1] = m_lfsr[3];
            if (m_fcnt == FT - 1) begin m_st = S_ESC; m_dir[1] = 1; end
            m_fcnt++;
          end
        S_SHOT: if (m_tick) begin
          m_hcnt++;
          if (m_hcnt == HH) begin m_st = S_FALL; m_dir[1] = 0; end
        end
        S_FALL: if (m_tick) begin
          if (m_y + 6 >= 540) begin m_y = 540; m_fd = 1; m_st = S_SPAWN; end else m_y = m_y + 6;
        end
        S_ESC: if (m_tick) begin
          if (m_y < 3) begin m_y = 0; m_esc = 1; m_st = S_SPAWN; end else m_y = m_y - 3;
        end
        default: m_st = S_IDLE;
      endcase
      m_alive = (m_st == S_FLY) || (m_st == S_ESC);
      m_lfsr = lfsr_next(m_lfsr);
      m_cyc++;
    end
  end

  logic [29:0] dut_v, exp_v;
  localparam logic [29:0] RST_V = {12'd0, 12'd540, 2'b00, 3'b000};
  assign dut_v = {duck_xpos, duck_ypos, duck_dir, duck_alive, duck_fall_done, duck_escaped};
  assign exp_v = {m_x[11:0], m_y[11:0], m_dir, m_alive, m_fd, m_esc};

  task automatic test_reset();
    rst = 1; hunt_start = 0; duck_hit = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (dut_v !== RST_V) begin errors++; $display("FAIL reset_values got %h exp %h", dut_v, RST_V); end
    rst = 0;
    repeat (100) begin
      @(negedge clk);
      checks++; if (dut_v !== RST_V) begin errors++; $display("FAIL idle_hold got %h exp %h", dut_v, RST_V); end
    end
  endtask

  task automatic test_spawn_fly();
    hunt_start = 1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (duck_ypos !== 12'd540 || duck_dir[1] !== 1'b1 || duck_xpos > 12'd928 || duck_alive !== 1'b1) begin
      errors++; $display("FAIL spawn_pos got x=%0d y=%0d dir=%b alive=%b", duck_xpos, duck_ypos, duck_dir, duck_alive); end
    checks++; if (dut_v !== exp_v) begin errors++; $display("FAIL spawn_lfsr got %h exp %h", dut_v, exp_v); end
    repeat (4) @(negedge clk);
    checks++; if (duck_ypos !== 12'd534) begin errors++; $display("FAIL climb_rate got y=%0d exp 534", duck_ypos); end
    repeat (20) begin
      @(negedge clk);
      checks++; if (dut_v !== exp_v) begin errors++; $display("FAIL fly_trace got %h exp %h", dut_v, exp_v); end
    end
  endtask

  task automatic test_escape();
    int n, pulses;
    logic [11:0] x0;
    n = 0; pulses = 0;
    while (m_st != S_ESC && n < 200) begin @(negedge clk); n++; end
    checks++; if (m_st != S_ESC) begin errors++; $display("FAIL escape_entry timeout after %0d cycles", n); end
    x0 = duck_xpos;
    n = 0;
    while (m_st != S_FLY && n < 2000) begin
      checks++; if (dut_v !== exp_v) begin errors++; $display("FAIL escape_trace got %h exp %h", dut_v, exp_v); end
      if (m_st == S_ESC) begin
        checks++; if (duck_xpos !== x0 || duck_alive !== 1'b1) begin
          errors++; $display("FAIL escape_x got x=%0d alive=%b exp x=%0d alive=1", duck_xpos, duck_alive, x0); end
      end
      if (duck_escaped) begin
        pulses++;
        checks++; if (duck_ypos !== 12'd0) begin errors++; $display("FAIL escape_top got y=%0d exp 0", duck_ypos); end
      end
      @(negedge clk); n++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL escape_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_bounce_right();
    int n;
    bit [15:0] nx;
    hunt_start = 0;
    @(negedge clk);
    n = 0;
    nx = lfsr_next(m_lfsr);
    while (nx[10:0] != {1'b1, 10'd926} && n < 40000) begin
      @(negedge clk); n++; nx = lfsr_next(m_lfsr);
    end
    checks++; if (nx[10:0] != {1'b1, 10'd926}) begin errors++; $display("FAIL bounce_seed timeout after %0d cycles", n); end
    hunt_start = 1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (duck_xpos !== 12'd926 || duck_dir !== 2'b11) begin
      errors++; $display("FAIL bounce_spawn got x=%0d dir=%b exp x=926 dir=11", duck_xpos, duck_dir); end
    n = 0;
    while (duck_xpos == 12'd926 && n < 4) begin @(negedge clk); n++; end
    checks++; if (duck_xpos !== 12'd928 || duck_dir[0] !== 1'b0) begin
      errors++; $display("FAIL bounce_edge got x=%0d dir0=%b exp x=928 dir0=0", duck_xpos, duck_dir[0]); end
    n = 0;
    while (duck_xpos == 12'd928 && n < 4) begin @(negedge clk); n++; end
    checks++; if (duck_xpos !== 12'd924 || duck_dir[0] !== 1'b0) begin
      errors++; $display("FAIL bounce_back got x=%0d dir0=%b exp x=924 dir0=0", duck_xpos, duck_dir[0]); end
    checks++; if (dut_v !== exp_v) begin errors++; $display("FAIL bounce_trace got %h exp %h", dut_v, exp_v); end
  endtask

  task automatic test_hit_fall();
    int n, pulses;
    logic [11:0] hx, hy, py;
    n = 0; pulses = 0;
    while (!(m_st == S_FLY && (m_cyc % MD) == MD - 1) && n < 200) begin @(negedge clk); n++; end
    hx = duck_xpos; hy = duck_ypos;
    duck_hit = 1;
    @(negedge clk);
    duck_hit = 0;
    checks++; if (duck_xpos !== hx || duck_ypos !== hy || duck_alive !== 1'b0) begin
      errors++; $display("FAIL hit_freeze got x=%0d y=%0d alive=%b exp x=%0d y=%0d alive=0", duck_xpos, duck_ypos, duck_alive, hx, hy); end
    n = 0; py = duck_ypos;
    while (m_st != S_FLY && n < 1000) begin
      checks++; if (dut_v !== exp_v) begin errors++; $display("FAIL fall_trace got %h exp %h", dut_v, exp_v); end
      if (m_st == S_SHOT) begin
        checks++; if (duck_xpos !== hx || duck_ypos !== hy) begin
          errors++; $display("FAIL shot_hold got x=%0d y=%0d exp x=%0d y=%0d", duck_xpos, duck_ypos, hx, hy); end
      end
      if (duck_ypos != py) begin
        checks++; if (duck_ypos != py + 12'd6 && duck_ypos != 12'd540) begin
          errors++; $display("FAIL fall_step got y=%0d exp %0d", duck_ypos, py + 12'd6); end
      end
      if (duck_fall_done) begin
        pulses++;
        checks++; if (duck_ypos !== 12'd540) begin errors++; $display("FAIL fall_ground got y=%0d exp 540", duck_ypos); end
      end
      py = duck_ypos;
      @(negedge clk); n++;
    end
    checks++; if (pulses != 1 || duck_alive !== 1'b1) begin
      errors++; $display("FAIL fall_pulses got %0d alive=%b exp 1 alive=1", pulses, duck_alive); end
  endtask

  task automatic test_drop_hunt();
    int n;
    logic [29:0] held;
    n = 0;
    while (!(m_st == S_FLY && m_y <= 528 && (m_cyc % MD) == MD - 1) && n < 200) begin @(negedge clk); n++; end
    duck_hit = 1;
    @(negedge clk);
    duck_hit = 0;
    n = 0;
    while (m_st != S_FALL && n < 200) begin @(negedge clk); n++; end
    checks++; if (m_st != S_FALL) begin errors++; $display("FAIL drop_fall_entry timeout after %0d cycles", n); end
    held = {dut_v[29:5], 5'b0};
    hunt_start = 0;
    @(negedge clk);
    checks++; if ({dut_v[29:5], 5'b0} !== held || dut_v[2:0] !== 3'b000) begin
      errors++; $display("FAIL drop_idle got %h exp %h", dut_v, held); end
    repeat (20) begin
      @(negedge clk);
      checks++; if ({dut_v[29:5], 5'b0} !== held || dut_v[2:0] !== 3'b000) begin
        errors++; $display("FAIL drop_hold got %h exp %h", dut_v, held); end
    end
    duck_hit = 1;
    @(negedge clk);
    duck_hit = 0;
    repeat (10) begin
      @(negedge clk);
      checks++; if ({dut_v[29:5], 5'b0} !== held || dut_v[2:0] !== 3'b000) begin
        errors++; $display("FAIL idle_hit got %h exp %h", dut_v, held); end
    end
  endtask

  task automatic test_reset_mid();
    hunt_start = 1;
    repeat (12) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++; if (dut_v !== RST_V) begin errors++; $display("FAIL mid_reset got %h exp %h", dut_v, RST_V); end
    rst = 0;
    repeat (20) begin
      @(negedge clk);
      checks++; if (dut_v !== exp_v) begin errors++; $display("FAIL post_reset got %h exp %h", dut_v, exp_v); end
    end
  endtask

  task automatic test_random();
    repeat (3000) begin
      @(negedge clk);
      checks++; if (dut_v !== exp_v) begin errors++; $display("FAIL random_trace got %h exp %h st=%0d", dut_v, exp_v, m_st); end
      hunt_start = ($urandom_range(0, 99) < 97);
      duck_hit   = ($urandom_range(0, 19) == 0);
    end
    duck_hit = 0;
  endtask

  initial begin
    test_reset();
    test_spawn_fly();
    test_escape();
    test_bounce_right();
    test_hit_fall();
    test_drop_hunt();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
